mem_tile_copy: RTL and testbench

//  Tile-copy engine that drives the single-port 32-bit Memory block: copies a

---
 rtl/mem_tile_copy.sv | 172 +++++++++++++++++
 tb/tb_mem_tile_copy.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_tile_copy.sv
// Tile-copy engine for the single-port 32-bit Memory block.
// Copies a rows x cols sub-matrix from a source tile to a destination tile,
// each with its own row stride, in row-major order. Each element takes three
// cycles: present the read address, wait for the memory latency, write.
// Addresses come from a per-tile row pointer plus a column offset, so no
// multiplier is needed. All address arithmetic wraps modulo 2^AW.
module mem_tile_copy #(
    parameter int unsigned AW   = 16,
    parameter int unsigned DW   = 32,
    parameter int unsigned DIMW = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [AW-1:0]   src_base,
    input  logic [AW-1:0]   dst_base,
    input  logic [AW-1:0]   src_stride,
    input  logic [AW-1:0]   dst_stride,
    input  logic [DIMW-1:0] rows,
    input  logic [DIMW-1:0] cols,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   mem_address,
    output logic [DW-1:0]   mem_data,
    output logic            mem_wren,
    input  logic [DW-1:0]   mem_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_WR,
        S_FIN
    } state_t;

    state_t          state_q;

    // Copy parameters captured when a request is accepted
    logic [AW-1:0]   src_stride_q;
    logic [AW-1:0]   dst_stride_q;
    logic [DIMW-1:0] rows_q;
    logic [DIMW-1:0] cols_q;

    // Element position and row pointers (address of element (row_q, 0))
    logic [DIMW-1:0] row_q;
    logic [DIMW-1:0] col_q;
    logic [AW-1:0]   src_row_q;
    logic [AW-1:0]   dst_row_q;

    // Registered outputs
    logic            busy_q;
    logic            done_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic            wren_q;

    // Position after the current element has been written
    logic [DIMW-1:0] row_d;
    logic [DIMW-1:0] col_d;
    logic [AW-1:0]   src_row_d;
    logic [AW-1:0]   dst_row_d;
    logic            last_col;
    logic            last_row;
    logic            last_elem;
    logic [AW-1:0]   dst_addr_cur;
    logic [AW-1:0]   src_addr_next;

    // Next element position and addresses derived from the current position
    always_comb begin
        last_col      = (col_q == DIMW'(cols_q - DIMW'(1)));
        last_row      = (row_q == DIMW'(rows_q - DIMW'(1)));
        last_elem     = last_col && last_row;
        col_d         = last_col ? '0 : DIMW'(col_q + DIMW'(1));
        row_d         = last_col ? DIMW'(row_q + DIMW'(1)) : row_q;
        src_row_d     = last_col ? AW'(src_row_q + src_stride_q) : src_row_q;
        dst_row_d     = last_col ? AW'(dst_row_q + dst_stride_q) : dst_row_q;
        dst_addr_cur  = AW'(dst_row_q + AW'(col_q));
        src_addr_next = AW'(src_row_d + AW'(col_d));
    end

    // Copy sequencer: state, position counters and registered memory-port outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            src_row_q    <= '0;
            dst_row_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            wren_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wren_q <= 1'b0;
                    addr_q <= '0;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        src_stride_q <= src_stride;
                        dst_stride_q <= dst_stride;
                        rows_q       <= rows;
                        cols_q       <= cols;
                        row_q        <= '0;
                        col_q        <= '0;
                        src_row_q    <= src_base;
                        dst_row_q    <= dst_base;
                        if ((rows == '0) || (cols == '0)) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RD;
                            busy_q  <= 1'b1;
                            addr_q  <= src_base;
                        end
                    end
                end
                S_RD: begin
                    state_q <= S_LAT;
                end
                S_LAT: begin
                    // mem_q now reflects the read address presented in RD
                    state_q <= S_WR;
                    addr_q  <= dst_addr_cur;
                    data_q  <= mem_q;
                    wren_q  <= 1'b1;
                end
                S_WR: begin
                    wren_q    <= 1'b0;
                    row_q     <= row_d;
                    col_q     <= col_d;
                    src_row_q <= src_row_d;
                    dst_row_q <= dst_row_d;
                    if (last_elem) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        addr_q  <= '0;
                    end else begin
                        state_q <= S_RD;
                        addr_q  <= src_addr_next;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    wren_q  <= 1'b0;
                    addr_q  <= '0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_address = addr_q;
    assign mem_data    = data_q;
    assign mem_wren    = wren_q;

endmodule

// File: tb/tb_mem_tile_copy.sv
// Directed bench for mem_tile_copy with a synchronous single-port memory model.
// Memory word i is preloaded with {16'hD00D, i}, so expected write data is
// known by hand from the source address.
module tb_mem_tile_copy;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src_base = '0;
    logic [15:0] dst_base = '0;
    logic [15:0] src_stride = '0;
    logic [15:0] dst_stride = '0;
    logic [7:0]  rows = '0;
    logic [7:0]  cols = '0;
    logic        busy;
    logic        done;
    logic [15:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q = '0;

    logic [31:0] mem [65536];

    int n_checks = 0;
    int n_fail   = 0;

    // Trace of one run
    int          wr_n, rd_n, done_n, busy_n, busy_first, busy_last;
    logic [15:0] wr_a [64];
    logic [31:0] wr_d [64];
    int          wr_c [64];
    logic [15:0] rd_a [64];
    int          done_c [16];

    mem_tile_copy #(.AW(16), .DW(32), .DIMW(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .src_stride  (src_stride),
        .dst_stride  (dst_stride),
        .rows        (rows),
        .cols        (cols),
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    always #5 clock = ~clock;

    // Synchronous single-port memory: q valid the cycle after the address
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a request; start is sampled at the next edge (edge 0)
    task automatic issue(input logic [15:0] sb, input logic [15:0] ss,
                         input logic [15:0] db, input logic [15:0] ds,
                         input logic [7:0] r, input logic [7:0] c, input bit hold);
        src_base = sb; src_stride = ss; dst_base = db; dst_stride = ds;
        rows = r; cols = c; start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
    endtask

    // Record ncyc cycles starting at cycle 1; optionally pulse a stray start
    task automatic run_trace(input int ncyc, input int pulse_at);
        bit prev_rd;
        prev_rd = 1'b0;
        wr_n = 0; rd_n = 0; done_n = 0; busy_n = 0; busy_first = -1; busy_last = -1;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            if (mem_wren && wr_n < 64) begin
                wr_a[wr_n] = mem_address; wr_d[wr_n] = mem_data; wr_c[wr_n] = cyc; wr_n++;
            end
            if (busy && !mem_wren && !prev_rd && rd_n < 64) begin
                rd_a[rd_n] = mem_address; rd_n++;
            end
            prev_rd = busy && !mem_wren;
            if (done && done_n < 16) begin
                done_c[done_n] = cyc; done_n++;
            end
            if (busy) begin
                busy_n++;
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
            if (cyc == pulse_at) begin
                start = 1'b1; src_base = 16'h0600; dst_base = 16'h0700;
            end else if (pulse_at > 0) begin
                start = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b want 0", mem_wren); end
        n_checks++; if (mem_address !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got %h want 0000", mem_address); end
        n_checks++; if (mem_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", mem_data); end
        #2 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_copy();
        logic [15:0] exp_rd [6] = '{16'h0100, 16'h0101, 16'h0102, 16'h0104, 16'h0105, 16'h0106};
        logic [15:0] exp_wa [6] = '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0204, 16'h0205};
        logic [31:0] exp_wd [6] = '{32'hD00D0100, 32'hD00D0101, 32'hD00D0102,
                                    32'hD00D0104, 32'hD00D0105, 32'hD00D0106};
        int          exp_wc [6] = '{3, 6, 9, 12, 15, 18};
        issue(16'h0100, 16'd4, 16'h0200, 16'd3, 8'd2, 8'd3, 1'b0);
        run_trace(22, 0);
        n_checks++; if (wr_n !== 6) begin n_fail++; $display("FAIL basic_wr_count got %0d want 6", wr_n); end
        n_checks++; if (rd_n !== 6) begin n_fail++; $display("FAIL basic_rd_count got %0d want 6", rd_n); end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (rd_a[i] !== exp_rd[i]) begin n_fail++; $display("FAIL basic_rd_addr[%0d] got %h want %h", i, rd_a[i], exp_rd[i]); end
            n_checks++; if (wr_a[i] !== exp_wa[i]) begin n_fail++; $display("FAIL basic_wr_addr[%0d] got %h want %h", i, wr_a[i], exp_wa[i]); end
            n_checks++; if (wr_d[i] !== exp_wd[i]) begin n_fail++; $display("FAIL basic_wr_data[%0d] got %h want %h", i, wr_d[i], exp_wd[i]); end
            n_checks++; if (wr_c[i] !== exp_wc[i]) begin n_fail++; $display("FAIL basic_wr_cycle[%0d] got %0d want %0d", i, wr_c[i], exp_wc[i]); end
            n_checks++; if (mem[exp_wa[i]] !== exp_wd[i]) begin n_fail++; $display("FAIL basic_mem[%h] got %h want %h", exp_wa[i], mem[exp_wa[i]], exp_wd[i]); end
        end
        n_checks++; if (done_n !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", done_n); end
        n_checks++; if (done_c[0] !== 19) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 19", done_c[0]); end
        n_checks++; if (busy_first !== 1) begin n_fail++; $display("FAIL basic_busy_first got %0d want 1", busy_first); end
        n_checks++; if (busy_last !== 18) begin n_fail++; $display("FAIL basic_busy_last got %0d want 18", busy_last); end
        n_checks++; if (busy_n !== 18) begin n_fail++; $display("FAIL basic_busy_len got %0d want 18", busy_n); end
    endtask

    task automatic test_zero_dim();
        issue(16'h0100, 16'd1, 16'h0C00, 16'd1, 8'd0, 8'd5, 1'b0);
        run_trace(4, 0);
        n_checks++; if (done_n !== 1) begin n_fail++; $display("FAIL zero_done_count got %0d want 1", done_n); end
        n_checks++; if (done_c[0] !== 1) begin n_fail++; $display("FAIL zero_done_cycle got %0d want 1", done_c[0]); end
        n_checks++; if (wr_n !== 0) begin n_fail++; $display("FAIL zero_wr_count got %0d want 0", wr_n); end
        n_checks++; if (busy_n !== 0) begin n_fail++; $display("FAIL zero_busy_len got %0d want 0", busy_n); end
    endtask

    task automatic test_addr_wrap();
        logic [15:0] exp_rd [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        logic [31:0] exp_wd [4] = '{32'hD00DFFFE, 32'hD00DFFFF, 32'hD00D0000, 32'hD00D0001};
        issue(16'hFFFE, 16'd1, 16'h0300, 16'd1, 8'd1, 8'd4, 1'b0);
        run_trace(15, 0);
        n_checks++; if (wr_n !== 4) begin n_fail++; $display("FAIL wrap_wr_count got %0d want 4", wr_n); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rd_a[i] !== exp_rd[i]) begin n_fail++; $display("FAIL wrap_rd_addr[%0d] got %h want %h", i, rd_a[i], exp_rd[i]); end
            n_checks++; if (wr_a[i] !== 16'(16'h0300 + i)) begin n_fail++; $display("FAIL wrap_wr_addr[%0d] got %h want %h", i, wr_a[i], 16'(16'h0300 + i)); end
            n_checks++; if (wr_d[i] !== exp_wd[i]) begin n_fail++; $display("FAIL wrap_wr_data[%0d] got %h want %h", i, wr_d[i], exp_wd[i]); end
        end
        n_checks++; if (done_c[0] !== 13) begin n_fail++; $display("FAIL wrap_done_cycle got %0d want 13", done_c[0]); end
    endtask

    task automatic test_start_while_busy();
        logic [15:0] exp_rd [4] = '{16'h0400, 16'h0401, 16'h0408, 16'h0409};
        logic [15:0] exp_wa [4] = '{16'h0500, 16'h0501, 16'h0502, 16'h0503};
        logic [31:0] exp_wd [4] = '{32'hD00D0400, 32'hD00D0401, 32'hD00D0408, 32'hD00D0409};
        issue(16'h0400, 16'd8, 16'h0500, 16'd2, 8'd2, 8'd2, 1'b0);
        run_trace(16, 5);
        n_checks++; if (wr_n !== 4) begin n_fail++; $display("FAIL busy_start_wr_count got %0d want 4", wr_n); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rd_a[i] !== exp_rd[i]) begin n_fail++; $display("FAIL busy_start_rd_addr[%0d] got %h want %h", i, rd_a[i], exp_rd[i]); end
            n_checks++; if (wr_a[i] !== exp_wa[i]) begin n_fail++; $display("FAIL busy_start_wr_addr[%0d] got %h want %h", i, wr_a[i], exp_wa[i]); end
            n_checks++; if (wr_d[i] !== exp_wd[i]) begin n_fail++; $display("FAIL busy_start_wr_data[%0d] got %h want %h", i, wr_d[i], exp_wd[i]); end
        end
        n_checks++; if (done_n !== 1) begin n_fail++; $display("FAIL busy_start_done_count got %0d want 1", done_n); end
        n_checks++; if (done_c[0] !== 13) begin n_fail++; $display("FAIL busy_start_done_cycle got %0d want 13", done_c[0]); end
    endtask

    task automatic test_reset_mid_copy();
        int writes;
        writes = 0;
        issue(16'h0800, 16'd4, 16'h0900, 16'd4, 8'd1, 8'd4, 1'b0);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            if (mem_wren) writes++;
            tick();
        end
        // Now in cycle 8: LAT of the third element
        n_checks++; if (busy !== 1'b1 || mem_wren !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_state got busy=%b wren=%b want busy=1 wren=0", busy, mem_wren); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_checks++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL midrst_wren got %b want 0", mem_wren); end
        n_checks++; if (mem_address !== 16'h0000) begin n_fail++; $display("FAIL midrst_addr got %h want 0000", mem_address); end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (mem_wren) writes++;
        end
        n_checks++; if (writes !== 2) begin n_fail++; $display("FAIL midrst_writes got %0d want 2", writes); end
        n_checks++; if (mem[16'h0901] !== 32'hD00D0801) begin n_fail++; $display("FAIL midrst_mem901 got %h want D00D0801", mem[16'h0901]); end
        n_checks++; if (mem[16'h0902] !== 32'hD00D0902) begin n_fail++; $display("FAIL midrst_mem902 got %h want D00D0902", mem[16'h0902]); end
        #2 reset_n = 1'b1;
        tick();
        issue(16'h0800, 16'd4, 16'h0900, 16'd4, 8'd1, 8'd4, 1'b0);
        run_trace(15, 0);
        n_checks++; if (wr_n !== 4) begin n_fail++; $display("FAIL midrst_rerun_wr_count got %0d want 4", wr_n); end
        n_checks++; if (done_c[0] !== 13) begin n_fail++; $display("FAIL midrst_rerun_done_cycle got %0d want 13", done_c[0]); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem[16'(16'h0900 + i)] !== 32'(32'hD00D0800 + i)) begin n_fail++; $display("FAIL midrst_rerun_mem[%0d] got %h want %h", i, mem[16'(16'h0900 + i)], 32'(32'hD00D0800 + i)); end
        end
    endtask

    task automatic test_back_to_back();
        int exp_done [3] = '{4, 9, 14};
        int exp_wr [3]   = '{3, 8, 13};
        issue(16'h0A00, 16'd1, 16'h0B00, 16'd1, 8'd1, 8'd1, 1'b1);
        run_trace(16, 0);
        start = 1'b0;
        n_checks++; if (done_n !== 3) begin n_fail++; $display("FAIL b2b_done_count got %0d want 3", done_n); end
        n_checks++; if (wr_n !== 3) begin n_fail++; $display("FAIL b2b_wr_count got %0d want 3", wr_n); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (done_c[i] !== exp_done[i]) begin n_fail++; $display("FAIL b2b_done_cycle[%0d] got %0d want %0d", i, done_c[i], exp_done[i]); end
            n_checks++; if (wr_c[i] !== exp_wr[i]) begin n_fail++; $display("FAIL b2b_wr_cycle[%0d] got %0d want %0d", i, wr_c[i], exp_wr[i]); end
            n_checks++; if (wr_a[i] !== 16'h0B00 || wr_d[i] !== 32'hD00D0A00) begin n_fail++; $display("FAIL b2b_wr[%0d] got %h/%h want 0B00/D00D0A00", i, wr_a[i], wr_d[i]); end
        end
        for (int k = 0; k < 6; k++) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] <= {16'hD00D, i[15:0]};
        test_reset();
        test_basic_copy();
        test_zero_dim();
        test_addr_wrap();
        test_start_while_busy();
        test_reset_mid_copy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
